// File: rtl/eqn_serial.sv
// eqn_serial: multi-cycle equality comparator for two WIDTH-bit operands.
// Compares CHUNK bits per clock, least-significant chunk first, behind a
// start/busy/done handshake. Reports equality, the index of the first
// mismatching chunk, and a saturating count of equal results.
//
// Optional feature: define EQN_EARLY_EXIT_EN to end a comparison at the
// first mismatching chunk. Without it every comparison takes N cycles.
module eqn_serial #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2,
    parameter int CNTW  = 8,
    localparam int N    = WIDTH / CHUNK,
    localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  x,
    input  logic [WIDTH-1:0]  y,
    output logic              busy,
    output logic              done,
    output logic              eq,
    output logic [IDXW-1:0]   mm_idx,
    output logic [CNTW-1:0]   match_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              mm_found_q, mm_found_d;
    logic [IDXW-1:0]   mm_pend_q, mm_pend_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              eq_q, eq_d;
    logic [IDXW-1:0]   mm_idx_q, mm_idx_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    // Per-chunk inequality of the latched operands; the current chunk is
    // selected from this vector rather than with a variable part-select.
    logic [N-1:0]      chunk_ne;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chunk
            assign chunk_ne[gi] = |(x_q[gi*CHUNK +: CHUNK] ^ y_q[gi*CHUNK +: CHUNK]);
        end
    endgenerate

    logic cur_ne;
    logic last_chunk;
    logic finish;
    logic result_eq;

    assign cur_ne     = chunk_ne[idx_q];
    assign last_chunk = (idx_q == IDXW'(N - 1));
    assign result_eq  = !(mm_found_q || cur_ne);

`ifdef EQN_EARLY_EXIT_EN
    assign finish = last_chunk || cur_ne;
`else
    assign finish = last_chunk;
`endif

    // Next-state logic: operand capture, chunk walk and result publication.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        idx_d      = idx_q;
        mm_found_d = mm_found_q;
        mm_pend_d  = mm_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        eq_d       = eq_q;
        mm_idx_d   = mm_idx_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d        = x;
                    y_d        = y;
                    idx_d      = '0;
                    mm_found_d = 1'b0;
                    mm_pend_d  = '0;
                    busy_d     = 1'b1;
                    state_d    = CMP;
                end
            end
            CMP: begin
                // Only the first mismatch is remembered; later ones are ignored.
                if (cur_ne && !mm_found_q) begin
                    mm_found_d = 1'b1;
                    mm_pend_d  = idx_q;
                end
                idx_d = idx_q + IDXW'(1);
                if (finish) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    eq_d     = result_eq;
                    mm_idx_d = mm_found_q ? mm_pend_q : (cur_ne ? idx_q : '0);
                    if (result_eq && (cnt_q != {CNTW{1'b1}})) begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over any comparison in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            idx_q      <= '0;
            mm_found_q <= 1'b0;
            mm_pend_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            eq_q       <= 1'b0;
            mm_idx_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            idx_q      <= idx_d;
            mm_found_q <= mm_found_d;
            mm_pend_q  <= mm_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            eq_q       <= eq_d;
            mm_idx_q   <= mm_idx_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign eq        = eq_q;
    assign mm_idx    = mm_idx_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_eqn_serial.sv
// Testbench for eqn_serial: directed handshake/reset scenarios followed by
// random traffic, checked by a scoreboard fed from a chunk-level reference
// model. A second instance with a 2-bit counter exercises saturation.
module tb_eqn_serial;

    localparam int WIDTH = 8;
    localparam int CHUNK = 2;
    localparam int N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] x = '0;
    logic [WIDTH-1:0] y = '0;

    logic             busy, done, eq;
    logic [1:0]       mm_idx;
    logic [7:0]       match_cnt;

    logic             busy2, done2, eq2;
    logic [1:0]       mm_idx2;
    logic [1:0]       match_cnt2;

    eqn_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .eq(eq), .mm_idx(mm_idx), .match_cnt(match_cnt)
    );

    eqn_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK), .CNTW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
        .busy(busy2), .done(done2), .eq(eq2), .mm_idx(mm_idx2), .match_cnt(match_cnt2)
    );

    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [WIDTH-1:0] xv;
        logic [WIDTH-1:0] yv;
        int unsigned      acc_edge;
        int unsigned      done_edge;
        bit               eq;
        int unsigned      mm;
        int unsigned      c8;
        int unsigned      c2;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned eq_total = 0;

    // Reference model: first differing chunk found by a plain loop.
    function automatic void push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input int unsigned acc);
        exp_t        e;
        int unsigned k = N;
        int unsigned lat;
        for (int i = 0; i < N; i++) begin
            if (k == N && a[i*CHUNK +: CHUNK] != b[i*CHUNK +: CHUNK]) k = i;
        end
        e.xv = a;
        e.yv = b;
        e.eq = (a == b);
        e.mm = e.eq ? 0 : k;
`ifdef EQN_EARLY_EXIT_EN
        lat = e.eq ? N : k + 1;
`else
        lat = N;
`endif
        if (e.eq) eq_total++;
        e.c8 = (eq_total > 255) ? 255 : eq_total;
        e.c2 = (eq_total > 3) ? 3 : eq_total;
        e.acc_edge  = acc;
        e.done_edge = acc + lat;
        sb_q.push_back(e);
    endfunction

    // Monitor: checks busy every cycle and pops the scoreboard on each done.
    exp_t mon_e;
    logic mon_busy;
    always @(negedge clk) begin
        if (sb_q.size() > 0 && edge_cnt > sb_q[0].done_edge) begin
            total++; bad++;
            $display("FAIL done_timeout: no done by edge %0d (required at edge %0d)",
                     edge_cnt, sb_q[0].done_edge);
            void'(sb_q.pop_front());
        end
        mon_busy = (sb_q.size() > 0) && (edge_cnt >= sb_q[0].acc_edge) &&
                   (edge_cnt < sb_q[0].done_edge);
        total++;
        if (busy !== mon_busy) begin
            bad++;
            $display("FAIL busy: edge %0d got %b want %b", edge_cnt, busy, mon_busy);
        end
        if (done !== 1'b0) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_done: edge %0d got done=%b want 0", edge_cnt, done);
            end else begin
                mon_e = sb_q.pop_front();
                $display("txn x=%h y=%h eq=%0d mm_idx=%0d cnt=%0d cnt2=%0d edge=%0d",
                         mon_e.xv, mon_e.yv, eq, mm_idx, match_cnt, match_cnt2, edge_cnt);
                total++;
                if (edge_cnt != mon_e.done_edge) begin
                    bad++;
                    $display("FAIL latency: done at edge %0d want edge %0d", edge_cnt, mon_e.done_edge);
                end
                total++;
                if (eq !== mon_e.eq) begin
                    bad++;
                    $display("FAIL eq: got %b want %b", eq, mon_e.eq);
                end
                total++;
                if (mm_idx !== 2'(mon_e.mm)) begin
                    bad++;
                    $display("FAIL mm_idx: got %0d want %0d", mm_idx, mon_e.mm);
                end
                total++;
                if (match_cnt !== 8'(mon_e.c8)) begin
                    bad++;
                    $display("FAIL match_cnt: got %0d want %0d", match_cnt, mon_e.c8);
                end
                total++;
                if (match_cnt2 !== 2'(mon_e.c2) || done2 !== 1'b1) begin
                    bad++;
                    $display("FAIL match_cnt_sat: got %0d done2=%b want %0d done2=1",
                             match_cnt2, done2, mon_e.c2);
                end
            end
        end
    end

    // One stimulus slot: inputs change 1 time unit after the falling edge.
    task automatic drive(input logic s, input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv);
        @(negedge clk);
        #1;
        start = s;
        x     = xv;
        y     = yv;
        if (s && sb_q.size() == 0) push_exp(xv, yv, edge_cnt + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        sb_q.delete();
        eq_total = 0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || eq !== 1'b0 || mm_idx !== 2'd0 ||
            match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b eq=%b mm_idx=%0d cnt=%0d cnt2=%0d want all 0",
                     busy, done, eq, mm_idx, match_cnt, match_cnt2);
        end
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] rx, ry, mask;
        int unsigned      r, k;

        do_reset();

        // Equal operands, low/high chunk mismatches, first-mismatch retention.
        drive(1'b1, 8'hA5, 8'hA5); idle(6);
        drive(1'b1, 8'h01, 8'h00); idle(6);
        drive(1'b1, 8'h40, 8'h00); idle(6);
        drive(1'b1, 8'h44, 8'h00); idle(6);

        // Start while busy is ignored.
        drive(1'b1, 8'h3C, 8'h3C);
        drive(1'b1, 8'hFF, 8'h00);
        idle(6);

        // Start held through the done cycle is accepted with no bubble.
        drive(1'b1, 8'h3C, 8'h3C);
        for (int i = 0; i < N + 1; i++) drive(1'b1, 8'h12, 8'h13);
        idle(6);

        // Reset at the second compare edge aborts the operation.
        drive(1'b1, 8'hFF, 8'hFF);
        idle(1);
        do_reset();
        idle(8);

        // Five equal results in a row: 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h5A, 8'h5A);
            idle(4);
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else begin
                rx = 8'($urandom);
                case ($urandom_range(0, 3))
                    0, 1: ry = rx;
                    2: begin
                        k    = $urandom_range(0, N - 1);
                        mask = 8'($urandom_range(1, 3)) << (k * CHUNK);
                        ry   = rx ^ mask;
                    end
                    default: ry = 8'($urandom);
                endcase
                drive(r < 60, rx, ry);
            end
        end

        // Drain: bounded wait for the last outstanding result.
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) idle(1);
        idle(2);
        if (sb_q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain: %0d results outstanding, want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
